vga_sync_gen: RTL and testbench



---
 rtl/vga_timing_pkg.sv | 28 ++
 rtl/clk_en_div.sv | 37 +++
 rtl/vga_sync_gen_checker.sv | 47 ++++
 rtl/vga_sync_gen.sv | 127 ++++++++++++
 tb/tb_vga_sync_gen.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/vga_timing_pkg.sv
// Shared 640x480 @ 60 Hz timing constants and coordinate types.
// The renderer takes its HBP/VBP from here so both blocks agree on the visible window.
package vga_timing_pkg;

  localparam int unsigned COORD_W = 10;

  typedef logic [COORD_W-1:0] coord_t;
  // One spare bit so limits of exactly 1024 still compare correctly
  typedef logic [COORD_W:0]   span_t;

  localparam int unsigned HPIXELS = 800;
  localparam int unsigned VLINES  = 521;
  localparam int unsigned HSW     = 96;
  localparam int unsigned VSW     = 2;
  localparam int unsigned HBP     = 144;
  localparam int unsigned HFP     = 784;
  localparam int unsigned VBP     = 31;
  localparam int unsigned VFP     = 511;

  function automatic span_t widen(input coord_t c);
    return {1'b0, c};
  endfunction

  function automatic logic in_span(input span_t v, input span_t lo, input span_t hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/clk_en_div.sv
// Board-clock divider producing a one-clk enable at the end of every CLK_DIV-clk period.
// The enable is gated by clr_n so it is low during reset even when CLK_DIV=1.
module clk_en_div #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic clr_n,
  output logic pix_en
);

  localparam int unsigned      DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ZERO = DIV_W'(1'b0);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1'b1);

  logic [DIV_W-1:0] div_r;
  logic             wrap_s;

  // Last phase of the divider marks the pixel boundary
  always_comb begin
    wrap_s = (div_r == DIV_LAST);
  end

  // Divider phase counter, wrapping by equality
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      div_r <= DIV_ZERO;
    end else if (wrap_s) begin
      div_r <= DIV_ZERO;
    end else begin
      div_r <= div_r + DIV_ONE;
    end
  end

  assign pix_en = wrap_s & clr_n;

endmodule

// File: rtl/vga_sync_gen_checker.sv
// Invariants of the timing generator outputs; observes the top-level ports only.
module vga_sync_gen_checker #(
  parameter int unsigned HPIXELS = vga_timing_pkg::HPIXELS,
  parameter int unsigned VLINES  = vga_timing_pkg::VLINES,
  parameter int unsigned HSW     = vga_timing_pkg::HSW,
  parameter int unsigned VSW     = vga_timing_pkg::VSW
) (
  input logic       clk,
  input logic       clr_n,
  input logic [9:0] hc,
  input logic [9:0] vc,
  input logic       hsync,
  input logic       vsync,
  input logic       vidon,
  input logic       pix_en,
  input logic       frame_tick
);

  import vga_timing_pkg::*;

  localparam span_t  H_TOTAL_S = span_t'(HPIXELS);
  localparam span_t  V_TOTAL_S = span_t'(VLINES);
  localparam span_t  HSW_S     = span_t'(HSW);
  localparam span_t  VSW_S     = span_t'(VSW);
  localparam coord_t H_LAST    = coord_t'(HPIXELS - 1);
  localparam coord_t V_LAST    = coord_t'(VLINES - 1);

  hc_in_range: assert property (@(posedge clk) disable iff (!clr_n)
    widen(hc) < H_TOTAL_S);

  vc_in_range: assert property (@(posedge clk) disable iff (!clr_n)
    widen(vc) < V_TOTAL_S);

  tick_at_frame_end: assert property (@(posedge clk) disable iff (!clr_n)
    frame_tick |-> (pix_en && (hc == H_LAST) && (vc == V_LAST)));

  hsync_decode: assert property (@(posedge clk) disable iff (!clr_n)
    hsync == (widen(hc) >= HSW_S));

  vsync_decode: assert property (@(posedge clk) disable iff (!clr_n)
    vsync == (widen(vc) >= VSW_S));

  // The visible window sits after both sync pulses
  visible_outside_sync: assert property (@(posedge clk) disable iff (!clr_n)
    vidon |-> (hsync && vsync));

endmodule

// File: rtl/vga_sync_gen.sv
// 640x480 @ 60 Hz timing generator: pixel-rate enable, free-running hc/vc counters and
// sync/visible decode taken combinationally from the counters so the renderer sees one state.
module vga_sync_gen #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned HPIXELS = vga_timing_pkg::HPIXELS,
  parameter int unsigned VLINES  = vga_timing_pkg::VLINES,
  parameter int unsigned HSW     = vga_timing_pkg::HSW,
  parameter int unsigned VSW     = vga_timing_pkg::VSW,
  parameter int unsigned HBP     = vga_timing_pkg::HBP,
  parameter int unsigned HFP     = vga_timing_pkg::HFP,
  parameter int unsigned VBP     = vga_timing_pkg::VBP,
  parameter int unsigned VFP     = vga_timing_pkg::VFP
) (
  input  logic       clk,
  input  logic       clr_n,
  output logic [9:0] hc,
  output logic [9:0] vc,
  output logic       hsync,
  output logic       vsync,
  output logic       vidon,
  output logic       pix_en,
  output logic       frame_tick
);

  import vga_timing_pkg::*;

  localparam coord_t H_LAST = coord_t'(HPIXELS - 1);
  localparam coord_t V_LAST = coord_t'(VLINES - 1);
  localparam coord_t C_ZERO = 10'd0;
  localparam coord_t C_ONE  = 10'd1;
  localparam span_t  HSW_S  = span_t'(HSW);
  localparam span_t  VSW_S  = span_t'(VSW);
  localparam span_t  HBP_S  = span_t'(HBP);
  localparam span_t  HFP_S  = span_t'(HFP);
  localparam span_t  VBP_S  = span_t'(VBP);
  localparam span_t  VFP_S  = span_t'(VFP);

  coord_t hc_r;
  coord_t vc_r;
  logic   pix_en_s;
  logic   line_end_s;
  logic   frame_end_s;
  span_t  hc_w_s;
  span_t  vc_w_s;
  logic   hsync_s;
  logic   vsync_s;
  logic   vidon_s;

  clk_en_div #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_en_div (
    .clk    (clk),
    .clr_n  (clr_n),
    .pix_en (pix_en_s)
  );

  // End-of-line / end-of-frame by equality, so the counters can never overrun
  always_comb begin
    line_end_s  = (hc_r == H_LAST);
    frame_end_s = (vc_r == V_LAST);
  end

  // Horizontal pixel counter, advancing once per pixel period
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      hc_r <= C_ZERO;
    end else if (pix_en_s) begin
      if (line_end_s) begin
        hc_r <= C_ZERO;
      end else begin
        hc_r <= hc_r + C_ONE;
      end
    end else begin
      hc_r <= hc_r;
    end
  end

  // Vertical line counter, stepping only on the edge that wraps hc
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      vc_r <= C_ZERO;
    end else if (pix_en_s && line_end_s) begin
      if (frame_end_s) begin
        vc_r <= C_ZERO;
      end else begin
        vc_r <= vc_r + C_ONE;
      end
    end else begin
      vc_r <= vc_r;
    end
  end

  // Sync and visible-window decode from the registered counters
  always_comb begin
    hc_w_s  = widen(hc_r);
    vc_w_s  = widen(vc_r);
    hsync_s = (hc_w_s >= HSW_S);
    vsync_s = (vc_w_s >= VSW_S);
    vidon_s = in_span(hc_w_s, HBP_S, HFP_S) && in_span(vc_w_s, VBP_S, VFP_S);
  end

  assign hc         = hc_r;
  assign vc         = vc_r;
  assign hsync      = hsync_s;
  assign vsync      = vsync_s;
  assign vidon      = vidon_s;
  assign pix_en     = pix_en_s;
  assign frame_tick = pix_en_s & line_end_s & frame_end_s;

  vga_sync_gen_checker #(
    .HPIXELS (HPIXELS),
    .VLINES  (VLINES),
    .HSW     (HSW),
    .VSW     (VSW)
  ) u_checker (
    .clk        (clk),
    .clr_n      (clr_n),
    .hc         (hc_r),
    .vc         (vc_r),
    .hsync      (hsync_s),
    .vsync      (vsync_s),
    .vidon      (vidon_s),
    .pix_en     (pix_en_s),
    .frame_tick (frame_tick)
  );

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen using a reduced timing (20x12 frame) so whole frames fit
// in a short run; a second instance exercises CLK_DIV=1.
module tb_vga_sync_gen;

  localparam int CD    = 4;
  localparam int HP    = 20;
  localparam int VL    = 12;
  localparam int HSW_T = 3;
  localparam int VSW_T = 2;
  localparam int HBP_T = 5;
  localparam int HFP_T = 17;
  localparam int VBP_T = 4;
  localparam int VFP_T = 10;
  localparam int FRAME = HP * VL * CD;

  logic       clk;
  logic       clr_n;
  logic [9:0] hc, vc, hc1, vc1;
  logic       hsync, vsync, vidon, pix_en, frame_tick;
  logic       hsync1, vsync1, vidon1, pix_en1, frame_tick1;

  typedef struct packed {
    logic [9:0] hc;  logic [9:0] vc;
    logic hs; logic vs; logic vo; logic pe; logic ft;
    logic [9:0] hc1; logic [9:0] vc1;
    logic hs1; logic vs1; logic vo1; logic pe1; logic ft1;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   m_div, m_hc, m_vc, m1_hc, m1_vc;
  int   vid_pix, hs_low, vs_low, ft_cnt, pe_cnt;

  vga_sync_gen #(
    .CLK_DIV(CD), .HPIXELS(HP), .VLINES(VL), .HSW(HSW_T), .VSW(VSW_T),
    .HBP(HBP_T), .HFP(HFP_T), .VBP(VBP_T), .VFP(VFP_T)
  ) u_dut (
    .clk(clk), .clr_n(clr_n), .hc(hc), .vc(vc), .hsync(hsync), .vsync(vsync),
    .vidon(vidon), .pix_en(pix_en), .frame_tick(frame_tick)
  );

  vga_sync_gen #(
    .CLK_DIV(1), .HPIXELS(HP), .VLINES(VL), .HSW(HSW_T), .VSW(VSW_T),
    .HBP(HBP_T), .HFP(HFP_T), .VBP(VBP_T), .VFP(VFP_T)
  ) u_dut1 (
    .clk(clk), .clr_n(clr_n), .hc(hc1), .vc(vc1), .hsync(hsync1), .vsync(vsync1),
    .vidon(vidon1), .pix_en(pix_en1), .frame_tick(frame_tick1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference counters advanced once per rising edge
  task automatic model_edge();
    if (!clr_n) begin
      m_div = 0; m_hc = 0; m_vc = 0; m1_hc = 0; m1_vc = 0;
    end else begin
      if (m_div == CD - 1) begin
        if (m_hc == HP - 1) begin
          m_hc = 0;
          m_vc = (m_vc == VL - 1) ? 0 : m_vc + 1;
        end else begin
          m_hc = m_hc + 1;
        end
      end
      m_div = (m_div == CD - 1) ? 0 : m_div + 1;
      if (m1_hc == HP - 1) begin
        m1_hc = 0;
        m1_vc = (m1_vc == VL - 1) ? 0 : m1_vc + 1;
      end else begin
        m1_hc = m1_hc + 1;
      end
    end
  endtask

  function automatic exp_t predict();
    exp_t e;
    e.hc  = 10'(m_hc);
    e.vc  = 10'(m_vc);
    e.hs  = (m_hc >= HSW_T);
    e.vs  = (m_vc >= VSW_T);
    e.vo  = (m_hc >= HBP_T) && (m_hc < HFP_T) && (m_vc >= VBP_T) && (m_vc < VFP_T);
    e.pe  = clr_n && (m_div == CD - 1);
    e.ft  = e.pe && (m_hc == HP - 1) && (m_vc == VL - 1);
    e.hc1 = 10'(m1_hc);
    e.vc1 = 10'(m1_vc);
    e.hs1 = (m1_hc >= HSW_T);
    e.vs1 = (m1_vc >= VSW_T);
    e.vo1 = (m1_hc >= HBP_T) && (m1_hc < HFP_T) && (m1_vc >= VBP_T) && (m1_vc < VFP_T);
    e.pe1 = clr_n;
    e.ft1 = clr_n && (m1_hc == HP - 1) && (m1_vc == VL - 1);
    return e;
  endfunction

  // One clock: predict at the edge, compare at the following falling edge
  task automatic tick();
    exp_t e;
    @(posedge clk);
    model_edge();
    sb_q.push_back(predict());
    @(negedge clk);
    e = sb_q.pop_front();
    check("hc", hc, e.hc);
    check("vc", vc, e.vc);
    check("hsync", hsync, e.hs);
    check("vsync", vsync, e.vs);
    check("vidon", vidon, e.vo);
    check("pix_en", pix_en, e.pe);
    check("frame_tick", frame_tick, e.ft);
    check("div1_hc", hc1, e.hc1);
    check("div1_vc", vc1, e.vc1);
    check("div1_hsync", hsync1, e.hs1);
    check("div1_vsync", vsync1, e.vs1);
    check("div1_vidon", vidon1, e.vo1);
    check("div1_pix_en", pix_en1, e.pe1);
    check("div1_frame_tick", frame_tick1, e.ft1);
    if (pix_en && vidon) vid_pix++;
    if (!hsync) hs_low++;
    if (!vsync) vs_low++;
    if (frame_tick) ft_cnt++;
    if (pix_en) pe_cnt++;
  endtask

  initial begin
    int e_cnt;
    clr_n = 1'b0;
    m_div = 0; m_hc = 0; m_vc = 0; m1_hc = 0; m1_vc = 0;

    // Reset held for 10 clocks: everything low and zero
    repeat (10) tick();
    clr_n = 1'b1;

    // First pix_en lands in clock CD after release, i.e. after CD-1 edges
    e_cnt = 0;
    while (pix_en !== 1'b1 && e_cnt < 4 * CD) begin
      tick();
      e_cnt++;
    end
    check("first_pix_en_edges", e_cnt, CD - 1);
    tick();
    check("hc_after_first_pix", hc, 1);

    // One full frame period of aggregate counts
    vid_pix = 0; hs_low = 0; vs_low = 0; ft_cnt = 0; pe_cnt = 0;
    repeat (FRAME) tick();
    check("vidon_pixels_per_frame", vid_pix, (HFP_T - HBP_T) * (VFP_T - VBP_T));
    check("hsync_low_clks_per_frame", hs_low, HSW_T * CD * VL);
    check("vsync_low_clks_per_frame", vs_low, VSW_T * HP * CD);
    check("frame_ticks_per_frame", ft_cnt, 1);
    check("pix_en_per_frame", pe_cnt, HP * VL);

    // frame_tick spacing
    e_cnt = 0;
    while (frame_tick !== 1'b1 && e_cnt < 2 * FRAME) begin
      tick();
      e_cnt++;
    end
    e_cnt = 0;
    do begin
      tick();
      e_cnt++;
    end while (frame_tick !== 1'b1 && e_cnt < 2 * FRAME);
    check("frame_tick_spacing", e_cnt, FRAME);

    // Mid-frame reset, asserted and released away from the clock edge
    e_cnt = 0;
    while (!(m_hc == 10 && m_vc == 6) && e_cnt < 2 * FRAME) begin
      tick();
      e_cnt++;
    end
    check("reached_mid_frame", m_hc * 100 + m_vc, 1006);
    @(posedge clk);
    model_edge();
    #3 clr_n = 1'b0;
    #1;
    check("async_rst_hc", hc, 0);
    check("async_rst_vc", vc, 0);
    check("async_rst_pix_en", pix_en, 0);
    check("async_rst_div1_hc", hc1, 0);
    check("async_rst_div1_pix_en", pix_en1, 0);
    model_edge();
    @(posedge clk);
    model_edge();
    #3 clr_n = 1'b1;

    // frame_tick falls in clock FRAME after release, i.e. after FRAME-1 edges
    e_cnt = 0;
    while (frame_tick !== 1'b1 && e_cnt < 2 * FRAME) begin
      tick();
      e_cnt++;
    end
    check("frame_tick_after_release", e_cnt, FRAME - 1);
    tick();
    check("hc_wrap_after_tick", hc, 0);
    check("vc_wrap_after_tick", vc, 0);
    check("scoreboard_drained", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
